// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: state encoding, default
// sizing and the button-to-bit convention.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLASH = 3'd1,
        INPUT = 3'd2,
        MSG   = 3'd3
    } state_t;

    localparam int SEQ_LEN_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT = 200_000_000;

    // A right press enters a 1, a left press enters a 0.
    localparam logic BIT_RIGHT = 1'b1;
    localparam logic BIT_LEFT  = 1'b0;

endpackage

// File: rtl/simon_press_timer.sv
// Per-press timeout counter: counts while enabled, flags the last allowed
// cycle, and restarts from zero whenever cleared.
module simon_press_timer
    import simon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/simon_round_controller.sv
// Multi-round Simon sequencer: latches the pattern, requests growing flash
// prefixes, checks player presses with a timeout, and reports win/lose.
module simon_round_controller
    import simon_pkg::*;
#(
    parameter int SEQ_LEN        = SEQ_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pressed,
    input  logic       right_pressed,
    input  logic       left_pressed,
    input  logic [7:0] rng_value,
    input  logic       flash_done,
    input  logic       msg_done,
    output logic       flash_start,
    output logic [2:0] flash_round,
    output logic [7:0] pattern,
    output logic       msg_start,
    output logic       msg_win,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] LAST_ROUND = 3'(SEQ_LEN - 1);

    state_t     state, state_next;
    logic [2:0] round, round_next;
    logic [2:0] idx, idx_next;
    logic [7:0] pattern_next;
    logic       win_next;
    logic       any_press, press_ok, expired;

    simon_press_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != INPUT) || any_press),
        .enable  (state == INPUT),
        .expired (expired)
    );

    // Pressing both buttons at once is always a wrong answer.
    assign any_press = right_pressed || left_pressed;
    assign press_ok  = any_press && !(right_pressed && left_pressed) &&
                       ((right_pressed ? BIT_RIGHT : BIT_LEFT) == pattern[idx]);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        round_next   = round;
        idx_next     = idx;
        pattern_next = pattern;
        win_next     = msg_win;
        case (state)
            IDLE: if (start_pressed) begin
                pattern_next = rng_value;
                round_next   = '0;
                idx_next     = '0;
                state_next   = FLASH;
            end
            FLASH: if (flash_done) begin
                idx_next   = '0;
                state_next = INPUT;
            end
            INPUT: begin
                if (any_press) begin
                    if (!press_ok) begin
                        win_next   = 1'b0;
                        state_next = MSG;
                    end else if (idx != round) begin
                        idx_next = idx + 3'd1;
                    end else if (round == LAST_ROUND) begin
                        win_next   = 1'b1;
                        state_next = MSG;
                    end else begin
                        round_next = round + 3'd1;
                        state_next = FLASH;
                    end
                end else if (expired) begin
                    win_next   = 1'b0;
                    state_next = MSG;
                end
            end
            MSG: if (msg_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            round       <= '0;
            idx         <= '0;
            pattern     <= '0;
            msg_win     <= 1'b0;
            flash_start <= 1'b0;
            msg_start   <= 1'b0;
            busy        <= 1'b0;
            flash_round <= '0;
            state_dbg   <= '0;
        end else begin
            state       <= state_next;
            round       <= round_next;
            idx         <= idx_next;
            pattern     <= pattern_next;
            msg_win     <= win_next;
            flash_start <= (state_next == FLASH);
            msg_start   <= (state_next == MSG);
            busy        <= (state_next != IDLE);
            flash_round <= round_next;
            state_dbg   <= state_next;
        end
    end

endmodule

// File: tb/tb_simon_round_controller.sv
// Scoreboard bench for simon_round_controller with SEQ_LEN=3, TIMEOUT_CYCLES=16:
// the driver queues expected flash/message requests, a monitor checks them.
module tb_simon_round_controller;

    logic       clk = 1'b0;
    logic       reset, start_pressed, right_pressed, left_pressed;
    logic [7:0] rng_value;
    logic       flash_done, msg_done;
    logic       flash_start, msg_start, msg_win, busy;
    logic [2:0] flash_round, state_dbg;
    logic [7:0] pattern;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_msg;
        logic [2:0] round;
        logic       win;
        logic [7:0] pattern;
    } ev_t;

    ev_t exp_q[$];

    simon_round_controller #(.SEQ_LEN(3), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_pressed (start_pressed),
        .right_pressed (right_pressed),
        .left_pressed  (left_pressed),
        .rng_value     (rng_value),
        .flash_done    (flash_done),
        .msg_done      (msg_done),
        .flash_start   (flash_start),
        .flash_round   (flash_round),
        .pattern       (pattern),
        .msg_start     (msg_start),
        .msg_win       (msg_win),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every rising request edge consumes one queued expectation.
    task automatic consume(input logic is_msg);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_request: got is_msg=%0b round=%0d expected none", is_msg, flash_round);
        end else begin
            e = exp_q.pop_front();
            check("request_kind", 32'(is_msg), 32'(e.is_msg));
            if (e.is_msg) check("msg_win", 32'(msg_win), 32'(e.win));
            else          check("flash_round", 32'(flash_round), 32'(e.round));
            check("pattern", 32'(pattern), 32'(e.pattern));
        end
    endtask

    initial begin
        logic prev_f = 1'b0;
        logic prev_m = 1'b0;
        forever begin
            @(negedge clk);
            if (flash_start && !prev_f) consume(1'b0);
            if (msg_start && !prev_m)   consume(1'b1);
            prev_f = flash_start;
            prev_m = msg_start;
        end
    end

    function automatic ev_t fl(input logic [2:0] r, input logic [7:0] p);
        return '{is_msg: 1'b0, round: r, win: 1'b0, pattern: p};
    endfunction

    function automatic ev_t ms(input logic w, input logic [7:0] p);
        return '{is_msg: 1'b1, round: 3'd0, win: w, pattern: p};
    endfunction

    task automatic start_game(input logic [7:0] rng);
        rng_value = rng;
        exp_q.push_back(fl(3'd0, rng));
        start_pressed = 1'b1;
        @(negedge clk);
        start_pressed = 1'b0;
        rng_value = ~rng;
    endtask

    task automatic wait_flash();
        int n = 0;
        while (!flash_start && n < 100) begin @(negedge clk); n++; end
        if (!flash_start) begin
            checks++; errors++;
            $display("FAIL flash_start_timeout: got 0 expected 1");
        end
        repeat (5) @(negedge clk);
        flash_done = 1'b1;
        @(negedge clk);
        flash_done = 1'b0;
    endtask

    task automatic wait_msg();
        int n = 0;
        while (!msg_start && n < 100) begin @(negedge clk); n++; end
        if (!msg_start) begin
            checks++; errors++;
            $display("FAIL msg_start_timeout: got 0 expected 1");
        end
        repeat (5) @(negedge clk);
        msg_done = 1'b1;
        @(negedge clk);
        msg_done = 1'b0;
    endtask

    task automatic press(input logic right, input logic left);
        right_pressed = right;
        left_pressed  = left;
        @(negedge clk);
        right_pressed = 1'b0;
        left_pressed  = 1'b0;
    endtask

    task automatic ignored_start(input logic [7:0] rng);
        rng_value = rng;
        start_pressed = 1'b1;
        @(negedge clk);
        start_pressed = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start_pressed = 1'b1; right_pressed = 1'b0; left_pressed = 1'b0;
        rng_value = 8'hFF; flash_done = 1'b0; msg_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flash_start", 32'(flash_start), 0);
        check("rst_msg_start", 32'(msg_start), 0);
        check("rst_msg_win", 32'(msg_win), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pattern", 32'(pattern), 0);
        check("rst_flash_round", 32'(flash_round), 0);
        check("rst_state_dbg", 32'(state_dbg), 0);
        start_pressed = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Full win with pattern A5: bits 0..2 = right, left, right.
        start_game(8'hA5);
        wait_flash();
        exp_q.push_back(fl(3'd1, 8'hA5));
        press(1, 0);
        wait_flash();
        ignored_start(8'h3C);
        check("pattern_after_ignored_start", 32'(pattern), 32'hA5);
        press(1, 0);
        exp_q.push_back(fl(3'd2, 8'hA5));
        press(0, 1);
        wait_flash();
        press(1, 0);
        press(0, 1);
        exp_q.push_back(ms(1'b1, 8'hA5));
        press(1, 0);
        wait_msg();
        check("win_idle_state", 32'(state_dbg), 0);
        check("win_idle_busy", 32'(busy), 0);
        check("pattern_retained", 32'(pattern), 32'hA5);

        // Wrong second press in round 1 ends the game without another flash.
        start_game(8'hA5);
        wait_flash();
        exp_q.push_back(fl(3'd1, 8'hA5));
        press(1, 0);
        wait_flash();
        press(1, 0);
        exp_q.push_back(ms(1'b0, 8'hA5));
        press(1, 0);
        wait_msg();
        repeat (4) @(negedge clk);
        check("lose_idle_state", 32'(state_dbg), 0);
        check("lose_no_flash", 32'(flash_start), 0);

        // Both buttons together count as wrong.
        start_game(8'h5A);
        wait_flash();
        exp_q.push_back(ms(1'b0, 8'h5A));
        press(1, 1);
        wait_msg();

        // Timeout: no press for 16 INPUT cycles, result seen on cycle 17.
        start_game(8'hA5);
        exp_q.push_back(ms(1'b0, 8'hA5));
        wait_flash();
        repeat (15) @(negedge clk);
        check("timeout_cyc16_msg_start", 32'(msg_start), 0);
        check("timeout_cyc16_state", 32'(state_dbg), 2);
        @(negedge clk);
        check("timeout_cyc17_msg_start", 32'(msg_start), 1);
        check("timeout_cyc17_msg_win", 32'(msg_win), 0);
        wait_msg();

        // A press on the timeout cycle wins, then reset aborts FLASH round 1.
        start_game(8'hA5);
        wait_flash();
        repeat (15) @(negedge clk);
        exp_q.push_back(fl(3'd1, 8'hA5));
        press(1, 0);
        check("late_press_state", 32'(state_dbg), 1);
        check("late_press_flash_round", 32'(flash_round), 1);
        ignored_start(8'h3C);
        check("flash_ignores_start", 32'(pattern), 32'hA5);
        check("flash_still_requested", 32'(flash_start), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_flash_start", 32'(flash_start), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_state_dbg", 32'(state_dbg), 0);
        check("abort_pattern", 32'(pattern), 0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(state_dbg), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
